// File: rtl/maxpool2x2_stream_pkg.sv
// Shared definitions for the 2x2 max-pooling stage: LeNet-5 map sizes and block positions.
package maxpool2x2_stream_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;

    // Convolution output map widths (C1, C3) and their pooled widths (S2, S4).
    localparam int unsigned C1_W = 28;
    localparam int unsigned C3_W = 10;
    localparam int unsigned S2_W = 14;
    localparam int unsigned S4_W = 5;

    // Position of a pixel inside its 2x2 block: {row parity, col parity}.
    typedef enum logic [1:0] {
        POS_EE = 2'b00,
        POS_EO = 2'b01,
        POS_OE = 2'b10,
        POS_OO = 2'b11
    } blk_pos_e;

    function automatic blk_pos_e blk_pos(input logic row_odd, input logic col_odd);
        return blk_pos_e'({row_odd, col_odd});
    endfunction

endpackage

// File: rtl/maxpool2x2_stream_max2.sv
// Combinational signed maximum of two operands.
module max2_signed #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y
);

    // Ties return b; both operands carry the same value then.
    always_comb begin
        y = ($signed(a) > $signed(b)) ? a : b;
    end

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 signed max-pool over a raster-order feature map, one channel.
module maxpool2x2_stream
    import maxpool2x2_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned IMG_W      = C1_W,
    parameter int unsigned IMG_H      = C1_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    // Column counter keeps at least 2 bits so the row-buffer index (col>>1) is never empty.
    localparam int unsigned CW       = (IMG_W > 2) ? $clog2(IMG_W) : 2;
    localparam int unsigned RW       = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int unsigned BW       = CW - 1;
    localparam int unsigned RB_DEPTH = IMG_W / 2;

    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;

    logic [DATA_WIDTH-1:0] rowbuf [RB_DEPTH];
    logic [BW-1:0]         rb_idx;
    logic                  rb_we;
    logic [DATA_WIDTH-1:0] rb_rd;

    logic                  accept;
    logic                  col_last;
    logic                  row_last;
    blk_pos_e              pos;
    logic [DATA_WIDTH-1:0] pair_max;
    logic [DATA_WIDTH-1:0] blk_max;

    // Handshake and position decode for the pixel presented this cycle.
    always_comb begin
        in_ready = !out_valid_q || out_ready;
        accept   = in_valid && in_ready;
        col_last = (col_q == CW'(IMG_W - 1));
        row_last = (row_q == RW'(IMG_H - 1));
        pos      = blk_pos(row_q[0], col_q[0]);
        rb_idx   = col_q[CW-1:1];
        rb_rd    = rowbuf[rb_idx];
    end

    max2_signed #(.DATA_WIDTH(DATA_WIDTH)) u_max_pair (
        .a (hold_q),
        .b (in_data),
        .y (pair_max)
    );

    max2_signed #(.DATA_WIDTH(DATA_WIDTH)) u_max_blk (
        .a (rb_rd),
        .b (pair_max),
        .y (blk_max)
    );

    // Next-state: raster counters, hold register, row-buffer write strobe and output register.
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        hold_d      = hold_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        rb_we       = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end

            case (pos)
                POS_EE, POS_OE: hold_d = in_data;
                POS_EO:         rb_we  = 1'b1;
                POS_OO: begin
                    out_data_d  = blk_max;
                    out_valid_d = 1'b1;
                    out_last_d  = row_last && col_last;
                end
                default: ;
            endcase
        end
    end

    // Control and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q       <= '0;
            row_q       <= '0;
            hold_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    // Row buffer of even-row pair maxima; written on even rows before odd rows read it.
    always_ff @(posedge clk) begin
        if (rb_we) begin
            rowbuf[rb_idx] <= pair_max;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Self-checking bench: a 4x4 instance for directed cases and a 28x28 instance for random traffic.
module tb_maxpool2x2_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv   [2];
    logic [31:0] din  [2];
    logic        ordy [2];
    logic        ir   [2];
    logic        ov   [2];
    logic [31:0] od   [2];
    logic        ol   [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    maxpool2x2_stream #(.DATA_WIDTH(32), .IMG_W(4), .IMG_H(4)) dut4 (
        .clk       (clk),
        .reset     (rst_n),
        .in_valid  (iv[0]),
        .in_ready  (ir[0]),
        .in_data   (din[0]),
        .out_valid (ov[0]),
        .out_ready (ordy[0]),
        .out_data  (od[0]),
        .out_last  (ol[0])
    );

    maxpool2x2_stream #(.DATA_WIDTH(32), .IMG_W(28), .IMG_H(28)) dut28 (
        .clk       (clk),
        .reset     (rst_n),
        .in_valid  (iv[1]),
        .in_ready  (ir[1]),
        .in_data   (din[1]),
        .out_valid (ov[1]),
        .out_ready (ordy[1]),
        .out_data  (od[1]),
        .out_last  (ol[1])
    );

    // Reference model: whole-frame pixel store, block maxima computed from stored pixels.
    logic signed [31:0] pix  [2][784];
    int                 pos  [2];
    logic [32:0]        expm [2][8];
    int                 wr   [2];
    int                 rd   [2];
    logic               held [2];
    logic [32:0]        prev [2];
    int                 n_out  [2];
    int                 n_last [2];
    logic [32:0]        obs [$];
    logic [32:0]        eq  [$];

    task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic mon(input int id, input logic rn, input logic v, input logic r,
                       input logic [31:0] d, input logic o_v, input logic o_r,
                       input logic [31:0] o_d, input logic o_l);
        int w;
        int row;
        int col;
        int p;
        logic signed [31:0] m;
        w = (id == 0) ? 4 : 28;
        if (!rn) begin
            pos[id]  = 0;
            rd[id]   = wr[id];
            held[id] = 1'b0;
            chk("rst_out_valid", 33'(o_v), 33'(0));
            chk("rst_out_data", {1'b0, o_d}, 33'(0));
            return;
        end
        chk("in_ready", 33'(r), 33'(!o_v || o_r));
        chk("out_valid", 33'(o_v), 33'(wr[id] != rd[id]));
        if (held[id] && o_v) chk("hold_stable", {o_l, o_d}, prev[id]);
        held[id] = o_v && !o_r;
        prev[id] = {o_l, o_d};
        if (o_v && o_r) begin
            if (wr[id] != rd[id]) begin
                chk("out_pixel", {o_l, o_d}, expm[id][rd[id] % 8]);
                rd[id]++;
            end
            n_out[id]++;
            if (o_l) n_last[id]++;
            if (id == 0) obs.push_back({o_l, o_d});
        end
        if (v && r) begin
            p   = pos[id];
            row = p / w;
            col = p % w;
            pix[id][p] = d;
            if ((row % 2 == 1) && (col % 2 == 1)) begin
                m = pix[id][p - w - 1];
                if (pix[id][p - w] > m) m = pix[id][p - w];
                if (pix[id][p - 1] > m) m = pix[id][p - 1];
                if (pix[id][p] > m)     m = pix[id][p];
                expm[id][wr[id] % 8] = {(row == w - 1) && (col == w - 1), m};
                wr[id]++;
            end
            pos[id] = (p + 1) % (w * w);
        end
    endtask

    // Single compare process, sampled mid-cycle for both instances.
    always @(negedge clk) begin
        mon(0, rst_n, iv[0], ir[0], din[0], ov[0], ordy[0], od[0], ol[0]);
        mon(1, rst_n, iv[1], ir[1], din[1], ov[1], ordy[1], od[1], ol[1]);
    end

    task automatic send(input int id, input logic [31:0] d, input int gap_pct, input int rdy_pct);
        logic acc;
        acc = 1'b0;
        while (int'($urandom_range(99)) < gap_pct) begin
            iv[id]   = 1'b0;
            ordy[id] = (int'($urandom_range(99)) < rdy_pct);
            @(posedge clk); #1;
        end
        iv[id]  = 1'b1;
        din[id] = d;
        for (int t = 0; t < 300; t++) begin
            ordy[id] = (int'($urandom_range(99)) < rdy_pct);
            #1;
            acc = ir[id];
            @(posedge clk); #1;
            if (acc) break;
        end
        chk("accepted", 33'(acc), 33'(1));
        iv[id] = 1'b0;
    endtask

    task automatic drain(input int id, input int n);
        iv[id]   = 1'b0;
        ordy[id] = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_obs(input string nm);
        chk({nm, "_count"}, 33'(obs.size()), 33'(eq.size()));
        for (int i = 0; i < eq.size(); i++) begin
            if (i < obs.size()) chk(nm, obs[i], eq[i]);
        end
    endtask

    task automatic ramp_expect();
        eq.delete();
        eq.push_back({1'b0, 32'd5});
        eq.push_back({1'b0, 32'd7});
        eq.push_back({1'b0, 32'd13});
        eq.push_back({1'b1, 32'd15});
    endtask

    initial begin
        logic [31:0] sg [16];
        int last_before;

        for (int i = 0; i < 2; i++) begin
            iv[i] = 1'b0; din[i] = '0; ordy[i] = 1'b0;
            pos[i] = 0; wr[i] = 0; rd[i] = 0; held[i] = 1'b0; prev[i] = '0;
            n_out[i] = 0; n_last[i] = 0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 33'(ov[0]), 33'(0));
        chk("reset_out_data", {1'b0, od[1]}, 33'(0));
        chk("reset_out_last", 33'(ol[0]), 33'(0));
        chk("reset_in_ready", 33'(ir[1]), 33'(1));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Ramp 0..15 through the 4x4 map.
        obs.delete();
        for (int i = 0; i < 16; i++) send(0, 32'(i), 0, 100);
        drain(0, 4);
        ramp_expect();
        check_obs("ramp");

        // Signed blocks including extremes.
        sg = '{32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h00000000,
               32'hFFFFFF9C, 32'hFFFFFFFB, 32'hFFFFFFFE, 32'hFFFFFFF9,
               32'hFFFFFFF7, 32'h7FFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFA,
               32'hFFFFFFEC, 32'hFFFFFFE2, 32'hFFFFFFD8, 32'hFFFFFFCE};
        obs.delete();
        for (int i = 0; i < 16; i++) send(0, sg[i], 0, 100);
        drain(0, 4);
        eq.delete();
        eq.push_back({1'b0, 32'hFFFFFFFD});
        eq.push_back({1'b0, 32'h00000000});
        eq.push_back({1'b0, 32'h7FFFFFFF});
        eq.push_back({1'b1, 32'hFFFFFFFC});
        check_obs("signed");

        // Backpressure with a pending output.
        obs.delete();
        for (int i = 0; i < 6; i++) send(0, 32'(i), 0, 100);
        ordy[0] = 1'b0;
        iv[0]   = 1'b1;
        din[0]  = 32'd6;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_in_ready", 33'(ir[0]), 33'(0));
        chk("bp_out_data", {ol[0], od[0]}, {1'b0, 32'd5});
        ordy[0] = 1'b1;
        #1;
        chk("bp_release_ready", 33'(ir[0]), 33'(1));
        @(posedge clk); #1;
        iv[0] = 1'b0;
        chk("bp_after_transfer", 33'(ov[0]), 33'(0));
        for (int i = 7; i < 16; i++) send(0, 32'(i), 0, 100);
        drain(0, 4);
        ramp_expect();
        check_obs("backpressure");

        // Random gaps and backpressure over a full 28x28 frame.
        n_out[1]  = 0;
        n_last[1] = 0;
        for (int i = 0; i < 784; i++) send(1, $urandom, 50, 50);
        drain(1, 8);
        chk("rand_out_count", 33'(n_out[1]), 33'(196));
        chk("rand_last_count", 33'(n_last[1]), 33'(1));

        // Reset mid-frame with an output pending, then a clean frame.
        for (int i = 0; i < 6; i++) send(0, 32'(100 + i), 0, 100);
        ordy[0] = 1'b0;
        chk("pre_reset_valid", 33'(ov[0]), 33'(1));
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", 33'(ov[0]), 33'(0));
        chk("midreset_out_data", {1'b0, od[0]}, 33'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        obs.delete();
        for (int i = 0; i < 16; i++) send(0, 32'(i), 0, 100);
        drain(0, 4);
        ramp_expect();
        check_obs("after_reset");

        // Two frames back-to-back without idle cycles.
        obs.delete();
        last_before = n_last[0];
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 16; i++) send(0, 32'(i), 0, 100);
        drain(0, 4);
        ramp_expect();
        eq.push_back({1'b0, 32'd5});
        eq.push_back({1'b0, 32'd7});
        eq.push_back({1'b0, 32'd13});
        eq.push_back({1'b1, 32'd15});
        check_obs("back_to_back");
        chk("b2b_last_pulses", 33'(n_last[0] - last_before), 33'(2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
